// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap initiator.
// Holds the FSM state type, fixed cause/mode encodings and the interrupt cause helper.
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ENTER   = 2'b01,
        HANDLER = 2'b10,
        RETURN  = 2'b11
    } trap_state_t;

    localparam logic [31:0] CAUSE_ECALL_M       = 32'h0000_000B;
    localparam logic [1:0]  MTVEC_MODE_VECTORED = 2'b01;

    // Interrupt mcause: bit 31 set, code = base + source index.
    function automatic logic [31:0] irq_cause(input logic [31:0] base, input logic [31:0] idx);
        irq_cause = {1'b1, base[30:0] + idx[30:0]};
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Signal bundle between the trap initiator, the ID stage and the CSR file.
// master drives decode/CSR values and observes the trap outputs; slave is the trap initiator.
interface trap_ctrl_if #(parameter int N_IRQ = 4);

    logic             instr_valid;
    logic             stall;
    logic             ecall;
    logic             mret;
    logic [N_IRQ-1:0] irq_src;
    logic             mie_global;
    logic [31:0]      mie_mask;
    logic [31:0]      mtvec;
    logic [31:0]      mepc;
    logic [31:0]      pres_addr;

    logic [31:0]      mip;
    logic             trigger_trap;
    logic [31:0]      trap_cause;
    logic [31:0]      trap_epc;
    logic             pc_redirect;
    logic [31:0]      redirect_addr;
    logic             flush;
    logic             trapping;
    logic             double_fault;

    modport master (
        output instr_valid, stall, ecall, mret, irq_src, mie_global,
               mie_mask, mtvec, mepc, pres_addr,
        input  mip, trigger_trap, trap_cause, trap_epc, pc_redirect,
               redirect_addr, flush, trapping, double_fault
    );

    modport slave (
        input  instr_valid, stall, ecall, mret, irq_src, mie_global,
               mie_mask, mtvec, mepc, pres_addr,
        output mip, trigger_trap, trap_cause, trap_epc, pc_redirect,
               redirect_addr, flush, trapping, double_fault
    );

endinterface

// File: rtl/trap_ctrl_prio_enc.sv
// Lowest-index-first priority encoder over the enabled pending interrupts.
module trap_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top down so the lowest requesting index is the last to win.
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            o_idx = i_req[i] ? IDX_W'(i) : o_idx;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap initiator: takes ecall/interrupt traps, strobes cause/EPC into the CSR file,
// redirects and flushes fetch into the handler, and returns to mepc on MRET.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int N_IRQ    = 4,
    parameter int IRQ_BASE = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    trap_ctrl_if.slave  bus
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    trap_state_t      r_state, w_next;
    logic [N_IRQ-1:0] r_mip, w_pend;
    logic             w_accept, w_irq_valid, w_irq_take;
    logic             w_take_ecall, w_take_irq, w_ret_go, w_set_df;
    logic [IDX_W-1:0] w_irq_idx;
    logic [31:0]      w_cause, w_vec_base, w_target;
    logic             r_trigger, r_pc_redirect, r_flush, r_trapping, r_double_fault;
    logic [31:0]      r_cause, r_epc, r_redirect;
    logic             w_unused;

    assign w_accept   = bus.instr_valid & ~bus.stall;
    assign w_pend     = r_mip & bus.mie_mask[IRQ_BASE +: N_IRQ];
    assign w_irq_take = bus.mie_global & w_irq_valid & w_accept;
    assign w_unused   = &{1'b0, bus.mie_mask};

    trap_prio_enc #(.N(N_IRQ), .IDX_W(IDX_W)) u_prio (
        .i_req   (w_pend),
        .o_valid (w_irq_valid),
        .o_idx   (w_irq_idx)
    );

    // Next-state decode; interrupts are only considered in IDLE, so there is no nesting.
    always_comb begin
        w_next       = r_state;
        w_take_ecall = 1'b0;
        w_take_irq   = 1'b0;
        w_ret_go     = 1'b0;
        w_set_df     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ecall && w_accept) begin
                    w_take_ecall = 1'b1;
                    w_next       = ENTER;
                end else if (w_irq_take) begin
                    w_take_irq = 1'b1;
                    w_next     = ENTER;
                end else begin
                    w_next = IDLE;
                end
            end
            ENTER:   w_next = HANDLER;
            HANDLER: begin
                if (bus.mret && w_accept) begin
                    w_ret_go = 1'b1;
                    w_next   = RETURN;
                end else if (bus.ecall && w_accept) begin
                    w_set_df = 1'b1;
                    w_next   = HANDLER;
                end else begin
                    w_next = HANDLER;
                end
            end
            RETURN:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Cause and handler target for the trap being taken this cycle.
    always_comb begin
        w_vec_base = {bus.mtvec[31:2], 2'b00};
        if (w_take_irq) begin
            w_cause = irq_cause(32'(IRQ_BASE), 32'(w_irq_idx));
            if (bus.mtvec[1:0] == MTVEC_MODE_VECTORED) begin
                w_target = w_vec_base + ((32'(IRQ_BASE) + 32'(w_irq_idx)) << 2);
            end else begin
                w_target = w_vec_base;
            end
        end else begin
            w_cause  = CAUSE_ECALL_M;
            w_target = w_vec_base;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Pending-interrupt view, one cycle behind the request levels.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mip <= '0;
        end else begin
            r_mip <= bus.irq_src;
        end
    end

    // Output registers, loaded from the transition being taken so they align with the new state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_trigger      <= 1'b0;
            r_pc_redirect  <= 1'b0;
            r_flush        <= 1'b0;
            r_trapping     <= 1'b0;
            r_double_fault <= 1'b0;
            r_cause        <= 32'h0000_0000;
            r_epc          <= 32'h0000_0000;
            r_redirect     <= 32'h0000_0000;
        end else begin
            r_trigger      <= w_take_ecall | w_take_irq;
            r_pc_redirect  <= w_take_ecall | w_take_irq | w_ret_go;
            r_flush        <= w_take_ecall | w_take_irq | w_ret_go;
            r_trapping     <= (w_next == HANDLER) || (w_next == RETURN);
            r_double_fault <= r_double_fault | w_set_df;
            r_cause        <= (w_take_ecall | w_take_irq) ? w_cause   : 32'h0000_0000;
            r_epc          <= (w_take_ecall | w_take_irq) ? bus.pres_addr : 32'h0000_0000;
            r_redirect     <= (w_take_ecall | w_take_irq) ? w_target  : 32'h0000_0000;
        end
    end

    // The return target is mepc as seen during RETURN, so a late handler write still lands.
    assign bus.redirect_addr = (r_state == RETURN) ? bus.mepc : r_redirect;
    assign bus.mip           = 32'(r_mip) << IRQ_BASE;
    assign bus.trigger_trap  = r_trigger;
    assign bus.trap_cause    = r_cause;
    assign bus.trap_epc      = r_epc;
    assign bus.pc_redirect   = r_pc_redirect;
    assign bus.flush         = r_flush;
    assign bus.trapping      = r_trapping;
    assign bus.double_fault  = r_double_fault;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios followed by random traffic, every cycle
// compared against a transaction-level prediction of the trap behaviour.
module tb_trap_ctrl;

    localparam int N_IRQ    = 4;
    localparam int IRQ_BASE = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trap_ctrl_if #(.N_IRQ(N_IRQ)) bus ();

    trap_ctrl #(.N_IRQ(N_IRQ), .IRQ_BASE(IRQ_BASE)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Prediction state: a handler is in progress from trap acceptance until the return strobe ends.
    bit             m_busy;
    bit [N_IRQ-1:0] m_mip;
    bit             m_df;
    bit             e_trig, e_ret, e_pcr, e_trapping;
    logic [31:0]    e_cause, e_epc, e_redir;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Predict from the inputs held this cycle, clock once, then compare every output.
    task automatic cycle();
        bit          acc, take, ret_go, n_df, n_busy;
        int          win;
        logic [31:0] base, n_cause, n_epc, n_redir;
        acc     = bus.instr_valid && !bus.stall;
        take    = 1'b0;
        ret_go  = 1'b0;
        win     = -1;
        n_df    = m_df;
        n_cause = 32'h0;
        n_epc   = 32'h0;
        n_redir = 32'h0;
        base    = bus.mtvec & 32'hFFFF_FFFC;
        if (!m_busy) begin
            if (bus.ecall && acc) begin
                take    = 1'b1;
                n_cause = 32'd11;
                n_redir = base;
            end else if (bus.mie_global && acc) begin
                for (int i = N_IRQ - 1; i >= 0; i--)
                    if (m_mip[i] && bus.mie_mask[IRQ_BASE + i]) win = i;
                if (win >= 0) begin
                    take    = 1'b1;
                    n_cause = 32'h8000_0000 | 32'(IRQ_BASE + win);
                    n_redir = base + ((bus.mtvec[1:0] == 2'b01) ? 32'(4 * (IRQ_BASE + win)) : 32'd0);
                end
            end
            if (take) n_epc = bus.pres_addr;
        end else if (!e_trig && !e_ret) begin
            if (bus.mret && acc) ret_go = 1'b1;
            else if (bus.ecall && acc) n_df = 1'b1;
        end
        n_busy = take ? 1'b1 : (e_ret ? 1'b0 : m_busy);
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_mip = '0; m_df = 0;
            e_trig = 0; e_ret = 0; e_pcr = 0; e_trapping = 0;
            e_cause = 0; e_epc = 0; e_redir = 0;
        end else begin
            m_busy     = n_busy;
            m_mip      = bus.irq_src;
            m_df       = n_df;
            e_trig     = take;
            e_ret      = ret_go;
            e_pcr      = take | ret_go;
            e_trapping = n_busy & !take;
            e_cause    = n_cause;
            e_epc      = n_epc;
            e_redir    = n_redir;
        end
        #1;
        check("trigger_trap", 32'(bus.trigger_trap), 32'(e_trig));
        check("pc_redirect", 32'(bus.pc_redirect), 32'(e_pcr));
        check("flush", 32'(bus.flush), 32'(e_pcr));
        check("trapping", 32'(bus.trapping), 32'(e_trapping));
        check("double_fault", 32'(bus.double_fault), 32'(m_df));
        check("mip", bus.mip, 32'(m_mip) << IRQ_BASE);
        if (e_trig) begin
            check("trap_cause", bus.trap_cause, e_cause);
            check("trap_epc", bus.trap_epc, e_epc);
        end
        if (e_pcr) check("redirect_addr", bus.redirect_addr, e_ret ? bus.mepc : e_redir);
    endtask

    initial begin
        rst = 1'b1;
        bus.instr_valid = 0; bus.stall = 0; bus.ecall = 0; bus.mret = 0;
        bus.irq_src = '0; bus.mie_global = 0; bus.mie_mask = 32'h0;
        bus.mtvec = 32'h0; bus.mepc = 32'h0; bus.pres_addr = 32'h0;
        m_busy = 0; m_mip = '0; m_df = 0;
        e_trig = 0; e_ret = 0; e_pcr = 0; e_trapping = 0;
        e_cause = 0; e_epc = 0; e_redir = 0;
        cycle(); cycle();
        check("reset_trigger", 32'(bus.trigger_trap), 32'h0);
        check("reset_mip", bus.mip, 32'h0);
        rst = 1'b0;
        cycle();

        // ecall into a direct-mode handler
        bus.mtvec = 32'h0000_0100; bus.pres_addr = 32'h0000_0040;
        bus.instr_valid = 1; bus.ecall = 1;
        cycle();
        check("ecall_trigger", 32'(bus.trigger_trap), 32'h1);
        check("ecall_cause", bus.trap_cause, 32'h0000_000B);
        check("ecall_epc", bus.trap_epc, 32'h0000_0040);
        check("ecall_redirect", bus.redirect_addr, 32'h0000_0100);
        check("ecall_flush", 32'(bus.flush), 32'h1);
        bus.ecall = 0; bus.instr_valid = 0;
        cycle();
        check("ecall_trapping", 32'(bus.trapping), 32'h1);

        // mret together with ecall: mret wins, no double fault, return to updated mepc
        bus.mepc = 32'h0000_0044; bus.instr_valid = 1; bus.mret = 1; bus.ecall = 1;
        cycle();
        check("mret_redirect", 32'(bus.pc_redirect), 32'h1);
        check("mret_addr", bus.redirect_addr, 32'h0000_0044);
        check("mret_trapping", 32'(bus.trapping), 32'h1);
        check("mret_no_df", 32'(bus.double_fault), 32'h0);
        bus.mret = 0; bus.ecall = 0;
        cycle();
        check("idle_trapping", 32'(bus.trapping), 32'h0);

        // vectored interrupt from source 0
        bus.mie_global = 1; bus.mie_mask = 32'h0001_0000; bus.mtvec = 32'h0000_0201;
        bus.irq_src = 4'b0001;
        cycle();
        check("irq_visible", bus.mip, 32'h0001_0000);
        check("irq_not_yet", 32'(bus.trigger_trap), 32'h0);
        cycle();
        check("irq_trigger", 32'(bus.trigger_trap), 32'h1);
        check("irq_cause", bus.trap_cause, 32'h8000_0010);
        check("irq_redirect", bus.redirect_addr, 32'h0000_0240);
        bus.irq_src = 4'b0000;
        cycle();
        bus.mepc = 32'h0000_0080; bus.mret = 1;
        cycle();
        bus.mret = 0;
        cycle();

        // ecall and a pending irq together; the irq is taken after the later mret
        bus.irq_src = 4'b0001; bus.instr_valid = 0;
        cycle();
        bus.instr_valid = 1; bus.ecall = 1;
        cycle();
        check("both_cause", bus.trap_cause, 32'h0000_000B);
        bus.ecall = 0;
        cycle();
        bus.mret = 1;
        cycle();
        bus.mret = 0;
        cycle();
        check("after_ret_idle", 32'(bus.trigger_trap), 32'h0);
        cycle();
        check("pending_irq_taken", 32'(bus.trigger_trap), 32'h1);
        check("pending_irq_cause", bus.trap_cause, 32'h8000_0010);
        cycle();
        bus.mret = 1;
        cycle();
        bus.mret = 0; bus.irq_src = 4'b0000;
        cycle();

        // stall holds an interrupt off for three cycles
        bus.irq_src = 4'b0001; bus.stall = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_hold", 32'(bus.trigger_trap), 32'h0);
        end
        bus.stall = 0;
        cycle();
        check("stall_release", 32'(bus.trigger_trap), 32'h1);
        bus.irq_src = 4'b0000;
        cycle();

        // ecall inside the handler, then reset mid-handler
        bus.ecall = 1;
        cycle();
        check("df_set", 32'(bus.double_fault), 32'h1);
        check("df_no_trigger", 32'(bus.trigger_trap), 32'h0);
        bus.ecall = 0;
        cycle();
        rst = 1;
        cycle();
        check("rst_trapping", 32'(bus.trapping), 32'h0);
        check("rst_df", 32'(bus.double_fault), 32'h0);
        check("rst_redirect", 32'(bus.pc_redirect), 32'h0);
        rst = 0;
        cycle();

        // random traffic
        for (int n = 0; n < 800; n++) begin
            rst             = ($urandom_range(0, 99) == 0);
            bus.instr_valid = ($urandom_range(0, 3) != 0);
            bus.stall       = ($urandom_range(0, 4) == 0);
            bus.ecall       = ($urandom_range(0, 9) == 0);
            bus.mret        = ($urandom_range(0, 3) == 0);
            bus.irq_src     = ($urandom_range(0, 2) == 0) ? N_IRQ'($urandom) : bus.irq_src;
            bus.mie_global  = ($urandom_range(0, 3) != 0);
            bus.mie_mask    = $urandom;
            bus.mtvec       = $urandom;
            bus.mepc        = $urandom;
            bus.pres_addr   = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap initiator for the machine-mode CSR file. It decides when a trap is taken, produces the one-cycle trap strobe with cause and EPC that the CSR file captures, and redirects and flushes the fetch pipeline into the handler.
- It also handles MRET, which redirects fetch to the saved mepc and re-arms trap acceptance.
- Sits between the ID stage (ecall/mret decode, IF_ID_pres_addr) and the CSR file (mtvec, mepc, mie/mstatus.MIE).

Parameters:
- N_IRQ, 4, number of external level-sensitive interrupt sources; bit 0 is the UART.
- IRQ_BASE, 16, mcause code of irq_src[0]; source i uses code IRQ_BASE+i.

Ports:
- clk  in  1  system clock
- Rst  in  1  synchronous active-high reset
- instr_valid  in  1  ID-stage instruction valid
- stall  in  1  pipeline stall; no trap or mret is accepted while high
- ecall  in  1  ID-stage instruction is ECALL
- mret  in  1  ID-stage instruction is MRET
- irq_src  in  N_IRQ  interrupt request levels (irq_src[0] = uart_IRQ)
- mie_global  in  1  mstatus.MIE from the CSR file
- mie_mask  in  32  mie CSR
- mtvec  in  32  mtvec CSR
- mepc  in  32  mepc CSR
- pres_addr  in  32  IF_ID_pres_addr, the PC of the ID-stage instruction
- mip  out  32  registered pending view; bits [IRQ_BASE+N_IRQ-1:IRQ_BASE] are live, all others 0
- trigger_trap  out  1  one-cycle trap strobe to the CSR file
- trap_cause  out  32  mcause value; valid while trigger_trap is high
- trap_epc  out  32  mepc value; valid while trigger_trap is high
- pc_redirect  out  1  one-cycle fetch redirect
- redirect_addr  out  32  redirect target; valid while pc_redirect is high
- flush  out  1  flushes IF/ID and ID/EX; asserted together with pc_redirect
- trapping  out  1  high while the handler is active
- double_fault  out  1  sticky; set when an ecall arrives while trapping is high

Behaviour:
- Reset: state=IDLE. All outputs are 0, including mip and double_fault.
- mip: each bit for a live source is registered as irq_src[i] every cycle. An interrupt therefore becomes visible 1 cycle after irq_src rises.
- accept = instr_valid & ~stall.
- irq_take = mie_global & |(mip & mie_mask) & accept.
- States:
  - IDLE → ENTER when (ecall & accept) or irq_take.
    - Priority: ecall over interrupts.
    - Among interrupts, the lowest source index wins.
    - The winning cause and pres_addr are latched at this point.
    - mret in IDLE is ignored.
  - ENTER lasts exactly 1 cycle.
    - trigger_trap=1, pc_redirect=1 and flush=1.
    - trap_cause: 32'h0000_000B for ecall; {1'b1, 31'(IRQ_BASE+i)} for source i.
    - trap_epc: the latched pres_addr.
    - redirect_addr:
      - mtvec[1:0]==2'b01 and the trap is an interrupt: {mtvec[31:2],2'b00} + 4*(IRQ_BASE+i).
      - All other cases: {mtvec[31:2],2'b00}.
    - Next state: HANDLER.
  - HANDLER: trapping=1; interrupts are masked (no nesting).
    - ecall & accept sets double_fault and is otherwise ignored.
    - mret & accept → RETURN.
  - RETURN lasts exactly 1 cycle.
    - pc_redirect=1, flush=1, redirect_addr=mepc (sampled this cycle, so a CSR write to mepc in the handler is honoured).
    - trapping stays 1 during this cycle.
    - Next state: IDLE.
- Latency:
  - Detection in cycle N gives the trap strobe and redirect in cycle N+1.
  - The earliest new trap after RETURN is detected in the first IDLE cycle, so it is taken 2 cycles after the mret strobe.
- Simultaneous events:
  - ecall and irq together: ecall wins; the irq remains pending in mip.
  - mret and ecall together in HANDLER: mret wins and double_fault is not set.
- stall: holds detection. A stalled ecall is taken on the first unstalled cycle.
- Reset mid-ENTER/HANDLER/RETURN: next cycle is IDLE with all outputs 0; no partial strobe.
- double_fault: cleared only by Rst.

Decomposition:
- Package trap_pkg holds:
  - typedef enum logic[1:0] {IDLE, ENTER, HANDLER, RETURN} trap_state_t
  - constants CAUSE_ECALL_M = 32'h0000_000B and MTVEC_MODE_VECTORED = 2'b01
  - function irq_cause(idx)
- One sub-module, trap_prio_enc, is natural: the lowest-index-first encoder over (mip & mie_mask), producing a valid bit and an index.

Test Plan:
- Reset, then mtvec=32'h0000_0100, ecall with pres_addr=32'h0000_0040 → next cycle trigger_trap=1, trap_cause=32'h0000_000B, trap_epc=32'h40, redirect_addr=32'h100, flush=1; then trapping=1.
- mie_global=1, mie_mask bit16 set, irq_src[0] raised, mtvec=32'h0000_0201 → detection 1 cycle after the rise; trap_cause=32'h8000_0010, redirect_addr=32'h240.
- Simultaneous ecall and irq_src[0] → cause 32'h0000_000B. The irq is taken 2 cycles after a later mret if it is still asserted.
- In HANDLER, set mepc=32'h44 and issue mret → RETURN with pc_redirect=1, redirect_addr=32'h44; then IDLE and trapping=0.
- irq pending with stall=1 for 3 cycles → no trigger_trap; the trap is taken on the cycle after stall falls.
- ecall in HANDLER → double_fault=1, no trigger_trap. Assert Rst during HANDLER → all outputs 0 on the next cycle.
